// File: rtl/lsu.sv
// lsu: RV32 load/store unit, single outstanding access, IDLE/REQ/WAIT/RESP FSM.
// Optional macro LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of forcing alignment.
module lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mis_q;

  logic                  accept;
  logic                  trap;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [DATA_WIDTH-1:0] wdata_fmt;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic                  ld_sgn;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Force size alignment of the address and replicate store data across lanes.
  always_comb begin
    addr_eff  = req_addr;
    wdata_fmt = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: wdata_fmt = {4{req_wdata[7:0]}};
      2'b01: begin
        addr_eff[0] = 1'b0;
        wdata_fmt   = {2{req_wdata[15:0]}};
      end
      default: addr_eff[1:0] = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned exactly when alignment had to clear a low address bit.
  assign trap = (addr_eff[1:0] != req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign ld_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_h   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign ld_sgn = ~f3_q[2];

  // Select the addressed lane and sign/zero extend to the register width.
  always_comb begin
    load_ext = mem_rdata;
    unique case (f3_q[1:0])
      2'b00:   load_ext = {{24{ld_sgn & ld_b[7]}}, ld_b};
      2'b01:   load_ext = {{16{ld_sgn & ld_h[15]}}, ld_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = trap ? RESP : REQ;
      REQ:  if (mem_ready) state_nx = we_q ? RESP : WAIT;
      WAIT: if (mem_rvalid) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the request on accept and the load data on return.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= addr_eff;
        wdata_q <= wdata_fmt;
        rdata_q <= '0;
        mis_q   <= trap;
      end
      if (state == WAIT && mem_rvalid) rdata_q <= load_ext;
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;

  // Byte strobes for stores; loads drive none.
  always_comb begin
    mem_wstrb = 4'b0000;
    if (mem_we) begin
      unique case (f3_q[1:0])
        2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
        2'b01:   mem_wstrb = 4'b0011 << addr_q[1:0];
        default: mem_wstrb = 4'b1111;
      endcase
    end
  end

  assign resp_valid    = (state == RESP);
  assign resp_rdata    = resp_valid ? rdata_q : '0;
  assign resp_misalign = resp_valid && mis_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu.
// Expectations come from a byte/lane reference model of RV32 load/store rules.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int ncmp  = 0;
  int nfail = 0;

  lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes, byte offset, lane arithmetic.
  task automatic model(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] mw,
    output logic [31:0] e_addr,
    output logic [3:0]  e_strb,
    output logic [31:0] e_wd,
    output logic [31:0] e_rd,
    output logic        e_trap
  );
    int n;
    int off;
    longint v;
    longint m;
    case (f3)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      default:        n = 4;
    endcase
    off = int'(a % 4);
    e_trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    e_trap = (off % n) != 0;
`endif
    off = off - (off % n);
    e_addr = a - (a % 4);
    e_strb = we ? 4'(((1 << n) - 1) << off) : 4'h0;
    e_wd = 32'h0;
    if (we)
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    e_rd = 32'h0;
    if (!we && !e_trap) begin
      m = longint'(1) << (8 * n);
      v = (longint'(mw) >> (8 * off)) % m;
      if ((f3 == 3'b000 || f3 == 3'b001) && v >= m / 2) v = v - m;
      e_rd = v[31:0];
    end
  endtask

  // Drives one request, plays the memory side, and records what was observed.
  task automatic run_op(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] mw,
    input  int          rdly,
    input  int          vdly,
    output int          lat,
    output logic [31:0] rd,
    output logic        mis,
    output int          nresp,
    output int          nreq,
    output logic [31:0] b_addr,
    output logic [3:0]  b_strb,
    output logic [31:0] b_wd,
    output logic        b_we,
    output logic        stable,
    output logic        rdy_after
  );
    int g;
    int wcnt;
    logic inwait;
    logic done;
    g = 0;
    while (!req_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!req_ready) begin
      ncmp++; nfail++;
      $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom);
    req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rd = '0; mis = 1'b0; nresp = 0; nreq = 0;
    b_addr = '0; b_strb = '0; b_wd = '0; b_we = 1'b0;
    stable = 1'b1; rdy_after = 1'b0;
    wcnt = 0; inwait = 1'b0; done = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (inwait) begin
        if (wcnt >= vdly) begin
          mem_rvalid = 1'b1; mem_rdata = mw; inwait = 1'b0;
        end else wcnt++;
      end else if ($urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
      if (mem_req) begin
        if (nreq == 0) begin
          b_addr = mem_addr; b_strb = mem_wstrb;
          b_wd = mem_wdata; b_we = mem_we;
        end else if (mem_addr !== b_addr || mem_wstrb !== b_strb ||
                     mem_wdata !== b_wd || mem_we !== b_we)
          stable = 1'b0;
        nreq++;
        if (nreq > rdly) begin
          mem_ready = 1'b1;
          if (!mem_we) inwait = 1'b1;
        end
      end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; mis = resp_misalign;
        nresp++; done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      ncmp++; nfail++;
      $display("FAIL timeout: no resp_valid within 60 cycles, required one");
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (k == 0) rdy_after = req_ready;
      if (resp_valid) nresp++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h104; req_wdata = 32'h1234_5678;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    ncmp++;
    if (req_ready !== 1'b1) begin
      nfail++; $display("FAIL rst_ready: got %b want 1", req_ready);
    end
    ncmp++;
    if ({resp_valid, resp_misalign, resp_rdata} !== 34'h0) begin
      nfail++;
      $display("FAIL rst_resp: got v=%b m=%b d=%h want 0", resp_valid, resp_misalign, resp_rdata);
    end
    ncmp++;
    if ({mem_req, mem_we, mem_wstrb} !== 6'h0) begin
      nfail++;
      $display("FAIL rst_memctl: got req=%b we=%b strb=%h want 0", mem_req, mem_we, mem_wstrb);
    end
    ncmp++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      nfail++;
      $display("FAIL rst_membus: got a=%h d=%h want 0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    ncmp++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
      nfail++;
      $display("FAIL rst_release: got rdy=%b req=%b want 1 0", req_ready, mem_req);
    end
  endtask

  task automatic test_store_word;
    int lat, nresp, nreq;
    logic [31:0] rd, ba, bw;
    logic [3:0] bs;
    logic mis, bwe, st, ra;
    run_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0,
           lat, rd, mis, nresp, nreq, ba, bs, bw, bwe, st, ra);
    ncmp++;
    if (ba !== 32'h100 || bs !== 4'hF || bw !== 32'hDEAD_BEEF || bwe !== 1'b1) begin
      nfail++;
      $display("FAIL sw_bus: got a=%h s=%h d=%h we=%b want 100 f deadbeef 1", ba, bs, bw, bwe);
    end
    ncmp++;
    if (lat !== 2 || nresp !== 1) begin
      nfail++; $display("FAIL sw_lat: got lat=%0d n=%0d want 2 1", lat, nresp);
    end
  endtask

  task automatic test_load_byte;
    int lat, nresp, nreq;
    logic [31:0] rd, ba, bw;
    logic [3:0] bs;
    logic mis, bwe, st, ra;
    run_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_0011, 0, 0,
           lat, rd, mis, nresp, nreq, ba, bs, bw, bwe, st, ra);
    ncmp++;
    if (rd !== 32'hFFFF_FF80 || lat !== 3) begin
      nfail++; $display("FAIL lb: got d=%h lat=%0d want ffffff80 3", rd, lat);
    end
    ncmp++;
    if (ba !== 32'h200 || bs !== 4'h0 || bwe !== 1'b0) begin
      nfail++; $display("FAIL lb_bus: got a=%h s=%h we=%b want 200 0 0", ba, bs, bwe);
    end
    run_op(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0011, 0, 0,
           lat, rd, mis, nresp, nreq, ba, bs, bw, bwe, st, ra);
    ncmp++;
    if (rd !== 32'h0000_0080 || lat !== 3) begin
      nfail++; $display("FAIL lbu: got d=%h lat=%0d want 00000080 3", rd, lat);
    end
  endtask

  task automatic test_store_half_stall;
    int lat, nresp, nreq;
    logic [31:0] rd, ba, bw;
    logic [3:0] bs;
    logic mis, bwe, st, ra;
    run_op(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 3, 0,
           lat, rd, mis, nresp, nreq, ba, bs, bw, bwe, st, ra);
    ncmp++;
    if (nreq !== 4 || st !== 1'b1) begin
      nfail++; $display("FAIL sh_stall: got req_cycles=%0d stable=%b want 4 1", nreq, st);
    end
    ncmp++;
    if (ba !== 32'h100 || bs !== 4'hC || bw !== 32'hABCD_ABCD) begin
      nfail++; $display("FAIL sh_bus: got a=%h s=%h d=%h want 100 c abcdabcd", ba, bs, bw);
    end
    ncmp++;
    if (nresp !== 1 || lat !== 5 || rd !== 32'h0) begin
      nfail++; $display("FAIL sh_resp: got n=%0d lat=%0d d=%h want 1 5 0", nresp, lat, rd);
    end
  endtask

  task automatic test_misalign;
    int lat, nresp, nreq;
    logic [31:0] rd, ba, bw;
    logic [3:0] bs;
    logic mis, bwe, st, ra;
    run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0, 0,
           lat, rd, mis, nresp, nreq, ba, bs, bw, bwe, st, ra);
`ifdef LSU_MISALIGN_TRAP_EN
    ncmp++;
    if (nreq !== 0 || lat !== 1 || mis !== 1'b1 || rd !== 32'h0) begin
      nfail++;
      $display("FAIL lw_trap: got req=%0d lat=%0d mis=%b d=%h want 0 1 1 0", nreq, lat, mis, rd);
    end
`else
    ncmp++;
    if (ba !== 32'h100 || lat !== 3 || mis !== 1'b0 || rd !== 32'h1234_5678) begin
      nfail++;
      $display("FAIL lw_force: got a=%h lat=%0d mis=%b d=%h want 100 3 0 12345678", ba, lat, mis, rd);
    end
`endif
  endtask

  task automatic test_reset_midflight;
    int cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h80; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ncmp++;
    if (mem_req !== 1'b1) begin
      nfail++; $display("FAIL rq_enter: got mem_req=%b want 1", mem_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ncmp++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      nfail++; $display("FAIL rq_reset: got req=%b v=%b want 0 0", mem_req, resp_valid);
    end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ncmp++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
      nfail++; $display("FAIL wait_reset: got rdy=%b req=%b want 1 0", req_ready, mem_req);
    end
    cnt = 0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) cnt++;
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    ncmp++;
    if (cnt !== 0 || req_ready !== 1'b1) begin
      nfail++; $display("FAIL wait_abandon: got resp=%0d rdy=%b want 0 1", cnt, req_ready);
    end
  endtask

  task automatic test_random;
    int lat, nresp, nreq, rdly, vdly, e_lat, e_nreq;
    logic [31:0] a, wd, mw, rd, ba, bw, e_a, e_wd, e_rd;
    logic [3:0] bs, e_s;
    logic [2:0] f3;
    logic we, mis, bwe, st, ra, e_t;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom); f3 = 3'($urandom);
      a = $urandom; wd = $urandom; mw = $urandom;
      rdly = $urandom_range(0, 3); vdly = $urandom_range(0, 3);
      model(we, f3, a, wd, mw, e_a, e_s, e_wd, e_rd, e_t);
      e_lat  = e_t ? 1 : (we ? 2 + rdly : 3 + rdly + vdly);
      e_nreq = e_t ? 0 : rdly + 1;
      run_op(we, f3, a, wd, mw, rdly, vdly,
             lat, rd, mis, nresp, nreq, ba, bs, bw, bwe, st, ra);
      ncmp++;
      if (rd !== e_rd || mis !== e_t) begin
        nfail++;
        $display("FAIL rnd_resp[%0d] we=%b f3=%b a=%h: got d=%h m=%b want %h %b", i, we, f3, a, rd, mis, e_rd, e_t);
      end
      ncmp++;
      if (lat !== e_lat || nresp !== 1 || nreq !== e_nreq) begin
        nfail++;
        $display("FAIL rnd_timing[%0d]: got lat=%0d n=%0d req=%0d want %0d 1 %0d", i, lat, nresp, nreq, e_lat, e_nreq);
      end
      if (e_nreq > 0) begin
        ncmp++;
        if (ba !== e_a || bs !== e_s || bwe !== we || st !== 1'b1) begin
          nfail++;
          $display("FAIL rnd_bus[%0d] f3=%b a=%h: got a=%h s=%h we=%b st=%b want %h %h %b 1", i, f3, a, ba, bs, bwe, st, e_a, e_s, we);
        end
        if (we) begin
          ncmp++;
          if (bw !== e_wd) begin
            nfail++; $display("FAIL rnd_wdata[%0d] f3=%b: got %h want %h", i, f3, bw, e_wd);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, nresp, nreq;
    logic [31:0] a, mw, rd, ba, bw, e_a, e_wd, e_rd;
    logic [3:0] bs, e_s;
    logic [2:0] f3;
    logic mis, bwe, st, ra, e_t;
    for (int i = 0; i < 12; i++) begin
      f3 = (i % 2 == 0) ? 3'b101 : 3'b001;
      a = {$urandom_range(0, 255), 2'b00} + 32'(2 * (i % 2));
      mw = $urandom;
      model(1'b0, f3, a, 32'h0, mw, e_a, e_s, e_wd, e_rd, e_t);
      run_op(1'b0, f3, a, 32'h0, mw, 0, 0,
             lat, rd, mis, nresp, nreq, ba, bs, bw, bwe, st, ra);
      ncmp++;
      if (rd !== e_rd || lat !== 3 || ra !== 1'b1) begin
        nfail++;
        $display("FAIL b2b[%0d] a=%h: got d=%h lat=%0d rdy=%b want %h 3 1", i, a, rd, lat, ra, e_rd);
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rst = 1'b1;
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half_stall();
    test_misalign();
    test_reset_midflight();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
